// File: rtl/fir_pkg.sv
// fir_pkg
// Shared types and constants for the time-multiplexed FIR tap scheduler.
//   state_t    : controller state encoding (IDLE, MAC, OUT)
//   DEF_N      : default sample/coefficient width
//   DEF_TAPS   : default number of taps
//   acc_width  : accumulator width that cannot overflow for a given N/TAPS
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_N    = 4;
  localparam int DEF_TAPS = 10;

  // Each product is 2N bits; summing TAPS of them needs clog2(TAPS) extra bits.
  function automatic int acc_width(input int n, input int taps);
    return 2 * n + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank
// TAPSxN coefficient register file with one write port and one
// combinational read port.
//   clk, rst_n : clock and asynchronous active-low clear of every entry
//   we         : write strobe (already qualified by the parent)
//   addr, data : write index and value; indices >= TAPS are ignored
//   rd_addr    : read index (the current tap)
//   rd_data    : coefficient at rd_addr, zero for out-of-range indices
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int TAPS = DEF_TAPS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(TAPS)-1:0] addr,
  input  logic [N-1:0]            data,
  input  logic [$clog2(TAPS)-1:0] rd_addr,
  output logic [N-1:0]            rd_data
);

  localparam int AW = $clog2(TAPS);

  logic [N-1:0] h [TAPS];
  logic         addr_ok;
  logic         rd_ok;

  // The extra leading bit keeps the compare valid when TAPS is a power of two.
  assign addr_ok = ({1'b0, addr} < (AW + 1)'(TAPS));
  assign rd_ok   = ({1'b0, rd_addr} < (AW + 1)'(TAPS));

  // Coefficient storage: cleared on reset, one entry written per strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) h[k] <= '0;
    end else if (we && addr_ok) begin
      h[addr] <= data;
    end
  end

  assign rd_data = rd_ok ? h[rd_addr] : '0;

endmodule

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler
// Time-multiplexed FIR: one sample per input handshake, one tap per cycle
// through a single shared multiplier-accumulator, result on valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake, in_data is the sample
//   out_valid/out_ready : result handshake, y holds sum h[k]*x[k]
//   coef_we/addr/data   : coefficient write port, honoured only while idle
//   busy                : controller is computing or holding a result
module fir_tap_scheduler
  import fir_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int TAPS  = DEF_TAPS,
  parameter int ACC_W = acc_width(N, TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        y,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]            coef_data,
  output logic                    busy
);

  localparam int             AW       = $clog2(TAPS);
  localparam logic [AW-1:0]  LAST_TAP = AW'(TAPS - 1);

  state_t           state;
  logic [AW-1:0]    tap;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [N-1:0]     x [TAPS];
  logic [N-1:0]     x_tap;
  logic [N-1:0]     h_tap;
  logic [2*N-1:0]   product;
  logic             coef_wr;
  logic             tap_ok;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Writes arriving mid-computation are dropped so the running sum stays coherent.
  assign coef_wr = coef_we && (state == IDLE);

  fir_coef_bank #(
    .N    (N),
    .TAPS (TAPS)
  ) u_coef_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (coef_wr),
    .addr    (coef_addr),
    .data    (coef_data),
    .rd_addr (tap),
    .rd_data (h_tap)
  );

  assign tap_ok   = ({1'b0, tap} < (AW + 1)'(TAPS));
  assign x_tap    = tap_ok ? x[tap] : '0;
  assign product  = {{N{1'b0}}, h_tap} * {{N{1'b0}}, x_tap};
  assign acc_next = acc + ACC_W'(product);

  // Controller, delay line and accumulator; y is loaded once on the last tap
  // so it stays frozen for the whole OUT phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= '0;
            tap   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + AW'(1);
          if (tap == LAST_TAP) begin
            y         <= acc_next;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb_fir_tap_scheduler
// Directed bench for fir_tap_scheduler with N=4, TAPS=10: table-driven
// unit/impulse/maximum responses plus hand-written sequences for output
// backpressure, writes while busy and reset mid-computation.
module tb_fir_tap_scheduler;

  localparam int N     = 4;
  localparam int TAPS  = 10;
  localparam int ACC_W = 12;
  localparam int AW    = 4;
  localparam int BOUND = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] y;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [N-1:0]     coef_data;
  logic             busy;

  typedef struct {
    int               group;
    logic [N-1:0]     sample;
    logic [ACC_W-1:0] exp_y;
  } vec_t;

  vec_t vecs [30];
  int   checks = 0;
  int   passes = 0;

  fir_tap_scheduler #(
    .N     (N),
    .TAPS  (TAPS),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic writeCoef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = N'(data);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic writeAll(input int data);
    for (int k = 0; k < TAPS; k++) writeCoef(k, data);
  endtask

  function automatic int coefFor(input int group, input int k);
    case (group)
      0:       return 1;
      1:       return k;
      default: return 15;
    endcase
  endfunction

  // Counts rising edges after an acceptance edge until out_valid is seen.
  task automatic waitOut(output int lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < BOUND) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic finishOut(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({name, " out_valid after handshake"}, int'(out_valid), 0);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] d, input int exp_y, input string name);
    int lat;
    for (int i = 0; i < BOUND && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitOut(lat);
    checkOutput({name, " latency"}, lat, TAPS);
    checkOutput({name, " y"}, int'(y), exp_y);
    checkOutput({name, " in_ready during out_valid"}, int'(in_ready), 0);
    finishOut(name);
  endtask

  initial begin
    int lat;
    int seen_valid;

    for (int k = 0; k < TAPS; k++) begin
      vecs[k]      = '{0, 4'd1, ACC_W'(k + 1)};
      vecs[10 + k] = '{1, (k == 0) ? 4'd1 : 4'd0, ACC_W'(k)};
      vecs[20 + k] = '{2, 4'd15, ACC_W'(225 * (k + 1))};
    end

    doReset();
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset y", int'(y), 0);
    checkOutput("reset busy", int'(busy), 0);

    // Unit, impulse and maximum-value responses.
    for (int i = 0; i < 30; i++) begin
      if (i == 0 || vecs[i].group != vecs[i-1].group) begin
        doReset();
        for (int k = 0; k < TAPS; k++) writeCoef(k, coefFor(vecs[i].group, k));
      end
      applyStimulus(vecs[i].sample, int'(vecs[i].exp_y), $sformatf("vec%0d", i));
    end

    // Output backpressure with a sample waiting at the input.
    doReset();
    writeAll(1);
    in_valid = 1'b1;
    in_data  = 4'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitOut(lat);
    checkOutput("bp first latency", lat, TAPS);
    checkOutput("bp first y", int'(y), 1);
    in_valid = 1'b1;
    in_data  = 4'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp hold%0d out_valid", c), int'(out_valid), 1);
      checkOutput($sformatf("bp hold%0d y", c), int'(y), 1);
      checkOutput($sformatf("bp hold%0d in_ready", c), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("bp after handshake out_valid", int'(out_valid), 0);
    checkOutput("bp after handshake in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("bp accepted next edge", int'(busy), 1);
    waitOut(lat);
    checkOutput("bp second latency", lat, TAPS);
    checkOutput("bp second y", int'(y), 4);
    finishOut("bp second");

    // Coefficient write during MAC is dropped; the same write in IDLE lands.
    doReset();
    writeAll(1);
    in_valid = 1'b1;
    in_data  = 4'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 4'd7;
    @(negedge clk);
    coef_we = 1'b0;
    waitOut(lat);
    checkOutput("busy write current y", int'(y), 2);
    finishOut("busy write current");
    applyStimulus(4'd1, 3, "busy write dropped");
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 4'd7;
    in_valid  = 1'b1;
    in_data   = 4'd1;
    @(posedge clk);
    #1;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    waitOut(lat);
    checkOutput("idle write with sample latency", lat, TAPS);
    checkOutput("idle write with sample y", int'(y), 10);
    finishOut("idle write with sample");
    writeCoef(10, 15);
    applyStimulus(4'd0, 4, "out-of-range write ignored");

    // Reset in the middle of MAC abandons the result and clears all state.
    doReset();
    writeAll(1);
    applyStimulus(4'd5, 5, "pre-reset");
    in_valid = 1'b1;
    in_data  = 4'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid reset out_valid", int'(out_valid), 0);
    checkOutput("mid reset y", int'(y), 0);
    checkOutput("mid reset in_ready", int'(in_ready), 1);
    seen_valid = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    checkOutput("mid reset no stray out_valid", seen_valid, 0);
    writeAll(1);
    applyStimulus(4'd1, 1, "post-reset unit");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_scheduler.md
# fir_tap_scheduler

Time-multiplexed controller for a TAPS-tap FIR filter. It accepts one sample per handshake and shifts it into a delay line. It then steps a single shared multiplier-accumulator over all taps, one tap per cycle, and presents the sum on a valid/ready output. Coefficients are held in a local bank written through a simple config port. It replaces a fully parallel multiplier array when area matters more than throughput.

## Interface
- N, 4: sample and coefficient width (unsigned).
- TAPS, 10: number of taps; must be ≥ 2.
- ACC_W, 2*N+$clog2(TAPS): accumulator and output width; with the defaults this is 12.

- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: sample offered.
- in_ready, output, 1: block can accept a sample; equals state==IDLE.
- in_data, input, N: sample.
- out_valid, output, 1: y holds a finished result.
- out_ready, input, 1: downstream accepts y.
- y, output, ACC_W: filter output, Σ h[k]·x[k] for k = 0..TAPS-1.
- coef_we, input, 1: coefficient write strobe.
- coef_addr, input, $clog2(TAPS): tap index.
- coef_data, input, N: coefficient value.
- busy, output, 1: state != IDLE.

## Operation
- **Delay line.** x[0] is the newest sample. On an input handshake, x[k] ← x[k-1] for k ≥ 1, and x[0] ← in_data.
- **States.** IDLE → MAC → OUT → IDLE.
  - **IDLE:** in_ready=1. On in_valid: shift the delay line, clear acc, set tap=0, go to MAC.
  - **MAC:** each cycle, acc ← acc + h[tap]·x[tap] and tap ← tap+1. The cycle with tap==TAPS-1 adds the last product and moves to OUT.
  - **OUT:** out_valid=1 and y=acc, both held stable. On out_ready, go to IDLE.
- **Arithmetic.** All arithmetic is unsigned. Products are 2N bits, zero-extended to ACC_W. ACC_W is sized so that acc never overflows; no saturation or wrap logic is needed.
- **Coefficient writes.**
  - A write with coef_we=1 is accepted only in IDLE: h[coef_addr] ← coef_data.
  - A write with coef_we=1 while busy=1 is dropped silently and does not corrupt the bank.
  - A write with coef_addr ≥ TAPS is ignored.
- **Simultaneous write and sample in IDLE.** coef_we and an in_valid handshake on the same IDLE cycle are both performed. The new coefficient is used by the computation that starts on that cycle.
- **Reset.** rst_n low asynchronously clears:
  - state to IDLE;
  - tap, acc, all x[k] and all h[k] to 0;
  - y to 0 and out_valid to 0.
  
  in_ready reads 1 whenever rst_n is high and the state is IDLE. A reset in the middle of MAC or OUT abandons the result; no out_valid pulse is produced for it.
- **Post-reset delay line.** After reset, the delay line is all zeros, so the first TAPS-1 outputs contain only partial history.

## Timing
- **Compute latency.** A sample accepted at rising edge E produces out_valid=1 after edge E+TAPS, i.e. TAPS cycles later.
- **Output hold.** y is registered and is not updated while out_valid=1.
- **Return to IDLE.** The output handshake at edge F returns the block to IDLE, so in_ready=1 after F. The earliest next sample acceptance is at edge F+1.
- **Throughput.** With out_ready held high and in_valid held high, the block accepts one sample every TAPS+2 cycles (12 cycles with defaults).
- **Flow control.** in_ready and out_valid are never both 1. No combinational path exists from in_valid to out_valid, or from out_ready to in_ready.
- **Coefficient write timing.** A write performed at edge W is visible to any computation accepted at an edge ≥ W.

## Structure
- **Package fir_pkg:**
  - state enum {IDLE, MAC, OUT};
  - default TAPS and N constants;
  - a width helper that returns ACC_W.
- **Sub-module fir_coef_bank:** the TAPS×N register file.
  - Write port: we, addr, data, gated by IDLE in the parent.
  - Combinational read port indexed by tap.
  - Async active-low clear.
- **Top level:** the FSM, the delay line, the single N×N multiplier and the accumulator stay in fir_tap_scheduler.

## Test plan
All scenarios use N=4, TAPS=10.
1. **Unit response.** Write all h=1, then feed ten samples of 1. → Outputs are 1, 2, …, 10 in order, each out_valid exactly 10 cycles after its acceptance.
2. **Impulse.** Write h[k]=k, then feed 1 followed by nine 0s. → y sequence is 0, 1, 2, …, 9.
3. **Maximum value.** Write all h=15, then feed ten samples of 15. → The tenth y is 2250, with no overflow in 12 bits.
4. **Output backpressure.** Hold out_ready=0 for 5 cycles during OUT. → y and out_valid stay stable, in_ready stays 0, and the next sample is accepted only after the handshake.
5. **Write while busy.** Assert coef_we to h[0]=7 during MAC. → The write is dropped and h[0] reads back unchanged. The same write issued in IDLE together with a new sample takes effect for that sample.
6. **Reset mid-computation.** Pull rst_n low at tap 5. → out_valid=0, y=0 and in_ready=1 immediately after release. The next unit-response output equals 1, showing that the delay line and coefficients were cleared.
